// File: rtl/adc_spi_receptor_pkg.sv
// -----------------------------------------------------------------------------
// adc_spi_receptor_pkg
// Shared constants for the AD7476-class serial receiver:
//   - FSM state encoding (IDLE, SHIFT, LATCH, WAIT)
//   - default frame geometry (16-bit frame = 4 leading zeros + 12 data bits)
//   - timing of the upstream frequency divider that generates SClk and CS
// -----------------------------------------------------------------------------
package adc_spi_receptor_pkg;

  // Frame geometry defaults
  localparam int N_BITS_DEF     = 16;
  localparam int DATA_W_DEF     = 12;
  localparam int LEAD_ZEROS_DEF = 4;
  localparam int CNT_W_DEF      = 8;

  // Upstream divider: SClk = MasterClk/32, CS low window = 1024 MasterClk
  // cycles, i.e. 32 SClk rising edges per frame (only the first 16 matter).
  localparam int SCLK_DIV  = 32;
  localparam int CS_WINDOW = 1024;

  // FSM state encoding
  localparam int         ST_W     = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

endpackage

// File: rtl/adc_spi_receptor_detector_flancos.sv
// -----------------------------------------------------------------------------
// detector_flancos
// Registered edge detector for a level that is already synchronous to clk.
// The level is registered once and compared with its live value, so the edge
// pulse is asserted in the same cycle the new level first appears.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (stored level resets 0)
//   sig_i       - level to watch
//   rise_o      - 1 for one cycle when sig_i goes 0->1
//   fall_o      - 1 for one cycle when sig_i goes 1->0
// -----------------------------------------------------------------------------
module detector_flancos (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  //       the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/adc_spi_receptor.sv
// -----------------------------------------------------------------------------
// adc_spi_receptor
// Receives one 16-bit frame per CS-low window from an AD7476-class ADC
// (4 leading zeros + 12 data bits, MSB first) using the SClk/CS levels
// produced by the upstream frequency divider.
// Ports:
//   MasterClk    - system clock (only clock)
//   reset        - asynchronous, active-low reset
//   SClk, CS     - divider levels, synchronous to MasterClk; frame while CS=0
//   SDATA        - ADC serial data, sampled on each detected SClk rise
//   Dato         - last captured sample (updated even on a leading-bit error)
//   Listo        - one-cycle strobe, Dato just updated
//   ErrorTrama   - 1 = last frame had nonzero leading bits or CS rose early
//   NumMuestras  - count of good frames, wraps
// -----------------------------------------------------------------------------
module adc_spi_receptor
  import adc_spi_receptor_pkg::*;
#(
  parameter int N_BITS     = N_BITS_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEAD_ZEROS = LEAD_ZEROS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              MasterClk,
  input  logic              reset,
  input  logic              SClk,
  input  logic              CS,
  input  logic              SDATA,
  output logic [DATA_W-1:0] Dato,
  output logic              Listo,
  output logic              ErrorTrama,
  output logic [CNT_W-1:0]  NumMuestras
);

  localparam int              BC_W     = $clog2(N_BITS);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(N_BITS - 1);

  logic sclk_rise, cs_fall, cs_rise;
  logic sclk_fall_unused;  // the FSM never needs the falling SClk edge

  detector_flancos u_det_sclk (
    .clk    (MasterClk),
    .rst_n  (reset),
    .sig_i  (SClk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall_unused)
  );

  // cs_q resets to 0, so a CS already low at reset release gives no cs_fall:
  // the partial frame in progress is skipped.
  detector_flancos u_det_cs (
    .clk    (MasterClk),
    .rst_n  (reset),
    .sig_i  (CS),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  logic [ST_W-1:0]   state_q, state_d;
  logic [N_BITS-1:0] shift_q, shift_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] dato_q, dato_d;
  logic              listo_q, listo_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // NOTE: every signal written here starts from a default (hold or 0), so no
  //       path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    dato_d   = dato_q;
    listo_d  = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d  = ST_SHIFT;
          shift_d  = '0;
          bitcnt_d = '0;
        end
      end

      ST_SHIFT: begin
        // An early CS rise aborts the frame even if SClk rose in this cycle.
        if (cs_rise) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          shift_d  = {shift_q[N_BITS-2:0], SDATA};
          bitcnt_d = bitcnt_q + BC_W'(1);
          if (bitcnt_q == LAST_BIT) state_d = ST_LATCH;
        end
      end

      ST_LATCH: begin
        dato_d  = shift_q[DATA_W-1:0];
        listo_d = 1'b1;
        if (shift_q[N_BITS-1 -: LEAD_ZEROS] == '0) begin
          err_d = 1'b0;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // The remaining SClk edges of the CS window carry no data.
        if (cs_rise) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MasterClk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      dato_q   <= '0;
      listo_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      dato_q   <= dato_d;
      listo_q  <= listo_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Dato        = dato_q;
  assign Listo       = listo_q;
  assign ErrorTrama  = err_q;
  assign NumMuestras = cnt_q;

endmodule

// File: tb/tb_adc_spi_receptor.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_receptor
// Drives SClk/CS frames and compares the receiver outputs with a frame-level
// reference model: a completed frame (16 SClk rises before CS rises) updates
// the sample; leading bits decide error vs. count; an early CS rise flags an
// error and leaves the sample alone.
// -----------------------------------------------------------------------------
module tb_adc_spi_receptor;
  import adc_spi_receptor_pkg::*;

  localparam int DATA_W = DATA_W_DEF;
  localparam int CNT_W  = CNT_W_DEF;
  localparam int NB     = N_BITS_DEF;

  logic              MasterClk = 1'b0;
  logic              reset;
  logic              SClk;
  logic              CS;
  logic              SDATA;
  logic [DATA_W-1:0] Dato;
  logic              Listo;
  logic              ErrorTrama;
  logic [CNT_W-1:0]  NumMuestras;

  adc_spi_receptor dut (
    .MasterClk   (MasterClk),
    .reset       (reset),
    .SClk        (SClk),
    .CS          (CS),
    .SDATA       (SDATA),
    .Dato        (Dato),
    .Listo       (Listo),
    .ErrorTrama  (ErrorTrama),
    .NumMuestras (NumMuestras)
  );

  always #5 MasterClk = ~MasterClk;

  int cyc = 0;
  always @(posedge MasterClk) cyc++;

  // Listo monitor, sampled on the falling edge
  int   pulses    = 0;
  int   hi_cycles = 0;
  int   listo_cyc = 0;
  logic listo_prev = 1'b0;
  always @(negedge MasterClk) begin
    if (Listo === 1'b1) begin
      hi_cycles++;
      if (listo_prev !== 1'b1) begin
        pulses++;
        listo_cyc = cyc;
      end
    end
    listo_prev = Listo;
  end

  // Reference model state
  logic [DATA_W-1:0] m_dato;
  logic              m_err;
  int                m_cnt;

  int vectors     = 0;
  int miscompares = 0;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge MasterClk);
    #1;
  endtask

  task automatic model_reset();
    m_dato = '0;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  // One CS window. abort_at=0: no abort. Otherwise CS rises after rise number
  // abort_at, or together with it when coincide=1.
  task automatic send_frame(input string tag, input logic [15:0] data,
                            input int n_rises, input int half,
                            input int abort_at, input bit coincide);
    int  p0, h0, drive_cyc, rises_before;
    bit  stopped, completed;
    p0 = pulses; h0 = hi_cycles; drive_cyc = -1000;
    stopped = 1'b0; rises_before = n_rises;
    CS = 1'b1; SClk = 1'b0; wait_cyc(4);
    CS = 1'b0; SDATA = data[15]; wait_cyc(half);
    for (int e = 1; e <= n_rises; e++) begin
      SClk = 1'b1;
      if (e == NB) drive_cyc = cyc;
      if (coincide && e == abort_at) begin
        CS = 1'b1; stopped = 1'b1; rises_before = e - 1;
      end
      wait_cyc(half);
      if (stopped) break;
      if (e == abort_at) begin
        CS = 1'b1; stopped = 1'b1; rises_before = e;
        break;
      end
      SClk = 1'b0;
      if (e < NB) SDATA = data[15-e];
      else        SDATA = 1'($urandom_range(0, 1));
      wait_cyc(half);
    end
    CS = 1'b1; SClk = 1'b0; wait_cyc(6);

    completed = (rises_before >= NB);
    if (completed) begin
      m_dato = data[DATA_W-1:0];
      if (data[15:12] == 4'h0) begin
        m_err = 1'b0;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_err = 1'b1;
    end

    vectors++;
    if (pulses - p0 !== int'(completed)) begin
      miscompares++;
      $display("FAIL %s listo_pulses: got %0d expected %0d", tag, pulses - p0, int'(completed));
    end
    vectors++;
    if (hi_cycles - h0 !== int'(completed)) begin
      miscompares++;
      $display("FAIL %s listo_width: got %0d high cycles expected %0d", tag, hi_cycles - h0, int'(completed));
    end
    vectors++;
    if (Dato !== m_dato) begin
      miscompares++;
      $display("FAIL %s dato: got %h expected %h", tag, Dato, m_dato);
    end
    vectors++;
    if (ErrorTrama !== m_err) begin
      miscompares++;
      $display("FAIL %s error_trama: got %b expected %b", tag, ErrorTrama, m_err);
    end
    vectors++;
    if (NumMuestras !== CNT_W'(m_cnt)) begin
      miscompares++;
      $display("FAIL %s num_muestras: got %0d expected %0d", tag, NumMuestras, m_cnt);
    end
    // Listo is visible two MasterClk edges after the 16th SClk high level.
    if (completed && pulses - p0 == 1) begin
      vectors++;
      if (listo_cyc - drive_cyc !== 2) begin
        miscompares++;
        $display("FAIL %s listo_latency: got %0d expected 2", tag, listo_cyc - drive_cyc);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; SClk = 1'b0; CS = 1'b1; SDATA = 1'b0;
    model_reset();
    wait_cyc(3);
    vectors++;
    if ({Dato, Listo, ErrorTrama, NumMuestras} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got dato=%h listo=%b err=%b cnt=%0d expected all 0",
               Dato, Listo, ErrorTrama, NumMuestras);
    end
    reset = 1'b1;
    wait_cyc(3);
  endtask

  task automatic test_good_frame();
    send_frame("good_0abc", 16'h0ABC, SCLK_DIV, SCLK_DIV/2, 0, 1'b0);
    vectors++;
    if (Dato !== 12'hABC || NumMuestras !== 8'd1) begin
      miscompares++;
      $display("FAIL good_0abc_abs: got dato=%h cnt=%0d expected abc/1", Dato, NumMuestras);
    end
  endtask

  task automatic test_lead_error();
    send_frame("lead_8123", 16'h8123, CS_WINDOW/SCLK_DIV, SCLK_DIV/2, 0, 1'b0);
    vectors++;
    if (Dato !== 12'h123 || ErrorTrama !== 1'b1 || NumMuestras !== 8'd1) begin
      miscompares++;
      $display("FAIL lead_8123_abs: got dato=%h err=%b cnt=%0d expected 123/1/1",
               Dato, ErrorTrama, NumMuestras);
    end
  endtask

  task automatic test_early_cs();
    send_frame("abort_10", 16'h0777, CS_WINDOW/SCLK_DIV, SCLK_DIV/2, 10, 1'b0);
    vectors++;
    if (Dato !== 12'h123) begin
      miscompares++;
      $display("FAIL abort_10_keep: got dato=%h expected 123", Dato);
    end
    send_frame("good_0555", 16'h0555, CS_WINDOW/SCLK_DIV, SCLK_DIV/2, 0, 1'b0);
    // CS and the 16th SClk rise in the same cycle: CS wins.
    send_frame("abort_coinc16", 16'h0999, CS_WINDOW/SCLK_DIV, SCLK_DIV/2, NB, 1'b1);
    send_frame("late_cs_after16", 16'h0246, NB, 4, NB, 1'b0);
  endtask

  task automatic test_reset_cs_low();
    int p0;
    reset = 1'b0; CS = 1'b0; SClk = 1'b0;
    model_reset();
    wait_cyc(2);
    reset = 1'b1;
    p0 = pulses;
    for (int e = 0; e < 20; e++) begin
      SClk = 1'b1; SDATA = 1'b0; wait_cyc(SCLK_DIV/2);
      SClk = 1'b0; wait_cyc(SCLK_DIV/2);
    end
    vectors++;
    if (pulses != p0 || Dato !== '0 || NumMuestras !== '0 || ErrorTrama !== 1'b0) begin
      miscompares++;
      $display("FAIL cs_low_release: got pulses=%0d dato=%h cnt=%0d err=%b expected 0/0/0/0",
               pulses - p0, Dato, NumMuestras, ErrorTrama);
    end
    send_frame("after_release_0fff", 16'h0FFF, CS_WINDOW/SCLK_DIV, SCLK_DIV/2, 0, 1'b0);
  endtask

  task automatic test_wrap();
    int start_cnt;
    start_cnt = m_cnt;
    for (int i = 0; i < 256; i++)
      send_frame("wrap", {4'h0, 12'($urandom)}, 32, 2, 0, 1'b0);
    vectors++;
    if (NumMuestras !== CNT_W'(start_cnt)) begin
      miscompares++;
      $display("FAIL wrap_256: got %0d expected %0d", NumMuestras, start_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [15:0] d;
      int          r, ab, hf;
      bit          co;
      d  = 16'($urandom);
      if ($urandom_range(0, 2) != 0) d[15:12] = 4'h0;
      hf = $urandom_range(2, 5);
      r  = $urandom_range(0, 3);
      ab = 0; co = 1'b0;
      if (r == 0) ab = $urandom_range(1, 15);
      else if (r == 1) begin ab = $urandom_range(1, 16); co = 1'b1; end
      send_frame("random", d, 32, hf, ab, co);
    end
  endtask

  task automatic test_reset_midframe();
    CS = 1'b1; SClk = 1'b0; wait_cyc(4);
    CS = 1'b0; SDATA = 1'b0; wait_cyc(SCLK_DIV/2);
    for (int e = 1; e <= 7; e++) begin
      SClk = 1'b1; wait_cyc(SCLK_DIV/2);
      if (e == 7) break;
      SClk = 1'b0; wait_cyc(SCLK_DIV/2);
    end
    wait_cyc(3);
    reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({Dato, Listo, ErrorTrama, NumMuestras} !== '0) begin
      miscompares++;
      $display("FAIL midframe_reset: got dato=%h listo=%b err=%b cnt=%0d expected all 0",
               Dato, Listo, ErrorTrama, NumMuestras);
    end
    CS = 1'b1; SClk = 1'b0;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(2);
    send_frame("after_reset_0001", 16'h0001, CS_WINDOW/SCLK_DIV, SCLK_DIV/2, 0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good_frame();
    test_lead_error();
    test_early_cs();
    test_reset_cs_low();
    test_wrap();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
